dmem_arbiter: RTL and testbench

- Shares the single-port 16x8 data memory between three requesters: CPU core (index 0), UART RX writer (index 1) and UART TX reader (index 2).
- Sits between the requesters and DATA_MEMORY. It drives the memory enable, write-enable, address and write data, and routes synchronous read data back to the requester that issued the read.
- Arbitration is fixed-priority core first, round-robin between RX and TX, with starvation counters that promote a waiting RX/TX above the core.

---
 rtl/dmem_arb_pkg.sv | 24 ++
 rtl/arb_wait_counter.sv | 25 ++
 rtl/dmem_arbiter.sv | 99 +++++++++
 tb/tb_dmem_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: requester indices, index type and read-return tag shared by the
// data-memory arbiter and its helpers.
package dmem_arb_pkg;

    typedef logic [1:0] req_idx_t;

    localparam req_idx_t REQ_CORE = 2'd0;
    localparam req_idx_t REQ_RX   = 2'd1;
    localparam req_idx_t REQ_TX   = 2'd2;
    localparam int       NREQ     = 3;

    typedef struct packed {
        logic     valid;
        req_idx_t idx;
    } rd_tag_t;

    function automatic logic [NREQ-1:0] onehot(input req_idx_t i);
        logic [NREQ-1:0] r;
        r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// arb_wait_counter: saturating count of consecutive lost arbitrations;
// urgent once the count reaches MAX_WAIT.
module arb_wait_counter #(
    parameter int MAX_WAIT = 3
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_lose,
    input  logic i_win,
    output logic o_urgent
);

    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = i_win ? 3'd0 : (i_lose && cnt_q != 3'd7) ? cnt_q + 3'd1 : cnt_q;
        o_urgent = cnt_q >= 3'(MAX_WAIT);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) cnt_q <= 3'd0;
        else            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between core, UART RX and
// UART TX; core has fixed priority, RX/TX round-robin with starvation promotion.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 3
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic [NREQ-1:0]        i_req,
    input  logic [NREQ-1:0]        i_we,
    input  logic [NREQ*ADDR_W-1:0] i_addr,
    input  logic [NREQ*DATA_W-1:0] i_wdata,
    output logic [NREQ-1:0]        o_gnt,
    output logic [NREQ-1:0]        o_rvalid,
    output logic [DATA_W-1:0]      o_rdata,
    output logic                   o_mem_en,
    output logic                   o_mem_we,
    output logic [ADDR_W-1:0]      o_mem_addr,
    output logic [DATA_W-1:0]      o_mem_wdata,
    input  logic [DATA_W-1:0]      i_mem_rdata
);

    logic [NREQ-1:0]   elig;
    logic              urg_rx, urg_tx, hot_rx, hot_tx, win_v, win_rx, win_tx;
    req_idx_t          win, ptr_q, ptr_d, idx_q;
    logic              en_q, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    rd_tag_t           tag_q, tag_d;

    // The requester granted this cycle is masked so its held request is not served twice.
    always_comb begin
        elig   = i_req & ~o_gnt;
        hot_rx = elig[REQ_RX] & urg_rx;
        hot_tx = elig[REQ_TX] & urg_tx;
        win_v  = |elig;
        win    = (hot_rx && hot_tx)               ? ptr_q    :
                 hot_rx                           ? REQ_RX   :
                 hot_tx                           ? REQ_TX   :
                 elig[REQ_CORE]                   ? REQ_CORE :
                 (elig[REQ_RX] && elig[REQ_TX])   ? ptr_q    :
                 elig[REQ_RX]                     ? REQ_RX   : REQ_TX;
        win_rx = win_v && win == REQ_RX;
        win_tx = win_v && win == REQ_TX;
        ptr_d  = win_rx ? REQ_TX : win_tx ? REQ_RX : ptr_q;
        tag_d  = '{valid: en_q & ~we_q, idx: idx_q};
    end

    arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait_rx (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_lose    (elig[REQ_RX] & ~win_rx),
        .i_win     (win_rx),
        .o_urgent  (urg_rx)
    );

    arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait_tx (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_lose    (elig[REQ_TX] & ~win_tx),
        .i_win     (win_tx),
        .o_urgent  (urg_tx)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            idx_q   <= REQ_CORE;
            addr_q  <= '0;
            wdata_q <= '0;
            ptr_q   <= REQ_RX;
            tag_q   <= '0;
        end else begin
            en_q  <= win_v;
            we_q  <= win_v & i_we[win];
            ptr_q <= ptr_d;
            tag_q <= tag_d;
            if (win_v) begin
                idx_q   <= win;
                addr_q  <= i_addr[win*ADDR_W +: ADDR_W];
                wdata_q <= i_wdata[win*DATA_W +: DATA_W];
            end
        end
    end

    // Read data comes straight from the memory's registered output, steered by the tag.
    assign o_gnt       = en_q ? onehot(idx_q) : '0;
    assign o_mem_en    = en_q;
    assign o_mem_we    = we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_rvalid    = tag_q.valid ? onehot(tag_q.idx) : '0;
    assign o_rdata     = tag_q.valid ? i_mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random traffic against a behavioural arbiter
// model; a monitor pops expected commands/read returns and compares.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW = 4, DW = 8, MW = 2;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] req = '0, we = '0, gnt, rvalid;
    logic [3*AW-1:0] addr = '0;
    logic [3*DW-1:0] wdata = '0;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic mem_en, mem_we;
    logic [AW-1:0] mem_addr;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) u_dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_req(req), .i_we(we), .i_addr(addr),
        .i_wdata(wdata), .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    logic [DW-1:0] mem [16];
    always @(posedge clk) if (mem_en) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else        mem_rdata <= mem[mem_addr];
    end

    int vectors = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", n, cyc, act, exp);
        end
    endtask

    typedef struct { int due; int idx; logic we; logic [AW-1:0] a; logic [DW-1:0] d; } cmd_t;
    typedef struct { int due; int idx; logic [DW-1:0] d; } rd_t;
    cmd_t cq[$];
    rd_t  rq[$];
    int wcnt[3], ptr, last;
    logic [DW-1:0] ref_mem [16];

    task automatic model_reset();
        wcnt = '{0, 0, 0};
        ptr  = 1;
        last = -1;
        cq.delete();
        rq.delete();
    endtask

    // Reference arbiter: decides this cycle's winner from the rules, plays accesses in grant order.
    always @(negedge clk) if (rst_n) begin
        automatic int w = -1;
        automatic bit e[3];
        automatic bit u1, u2, wr = 0;
        automatic logic [AW-1:0] a = '0;
        automatic logic [DW-1:0] d = '0;
        for (int k = 0; k < 3; k++) e[k] = req[k] && last != k;
        u1 = e[1] && wcnt[1] >= MW;
        u2 = e[2] && wcnt[2] >= MW;
        if (u1 && u2) w = ptr;
        else if (u1) w = 1;
        else if (u2) w = 2;
        else if (e[0]) w = 0;
        else if (e[1] && e[2]) w = ptr;
        else if (e[1]) w = 1;
        else if (e[2]) w = 2;
        for (int k = 1; k < 3; k++)
            if (w == k) wcnt[k] = 0;
            else if (e[k] && wcnt[k] < 7) wcnt[k]++;
        if (w > 0) ptr = 3 - w;
        last = w;
        if (w >= 0) begin
            a  = addr[w*AW +: AW];
            d  = wdata[w*DW +: DW];
            wr = we[w];
            if (wr) ref_mem[a] = d;
            else rq.push_back('{cyc + 2, w, ref_mem[a]});
        end
        cq.push_back('{cyc + 1, w, wr, a, d});
    end

    always @(posedge clk) begin
        #2;
        if (!rst_n) chk("reset_outputs", 32'({gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata}), 0);
        else begin
            automatic cmd_t c = '{0, -1, 1'b0, '0, '0};
            automatic rd_t r;
            if (cq.size() > 0 && cq[0].due == cyc) c = cq.pop_front();
            chk("grant", 32'(gnt), c.idx < 0 ? 0 : 32'(1) << c.idx);
            chk("mem_en", 32'(mem_en), 32'(c.idx >= 0));
            if (c.idx >= 0) chk("mem_cmd", 32'({mem_we, mem_addr, mem_wdata}), 32'({c.we, c.a, c.d}));
            if (rq.size() > 0 && rq[0].due == cyc) begin
                r = rq.pop_front();
                chk("rvalid", 32'(rvalid), 32'(1) << r.idx);
                chk("rdata", 32'(rdata), 32'(r.d));
            end else chk("rvalid_idle", 32'(rvalid), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int k, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[k] = 1'b1;
        we[k] = w;
        addr[k*AW +: AW] = a;
        wdata[k*DW +: DW] = d;
    endtask

    task automatic reset_pulse();
        tick();
        rst_n = 1'b0;
        req = '0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic cont(input logic [2:0] mask, input bit chk_cnt, output logic [11:0] seq);
        for (int k = 0; k < 3; k++) if (mask[k]) issue(k, 1'b0, AW'($urandom), 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick();
            seq[i*3 +: 3] = gnt;
            if (chk_cnt && gnt[1]) chk("rx_cnt_cleared", 32'(u_dut.u_wait_rx.cnt_q), 0);
            if (chk_cnt && gnt[2]) chk("tx_cnt_cleared", 32'(u_dut.u_wait_tx.cnt_q), 0);
        end
        req = '0;
        repeat (4) tick();
    endtask

    task automatic rand_run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                if (req[k] && gnt[k]) begin
                    if ($urandom % 4 != 0) issue(k, 1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom));
                    else req[k] = 1'b0;
                end else if (!req[k] && $urandom % 3 == 0)
                    issue(k, 1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom));
                else if (req[k] && $urandom % 40 == 0) req[k] = 1'b0;
            end
        end
        req = '0;
        repeat (6) tick();
    endtask

    initial begin
        logic [11:0] seq;
        logic [DW-1:0] got;
        int n;
        for (int i = 0; i < 16; i++) begin
            mem[i] = DW'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[5] = 8'hA5;
        ref_mem[5] = 8'hA5;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            req = 3'($urandom); we = 3'($urandom);
            addr = 12'($urandom); wdata = 24'($urandom);
        end
        req = '0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();

        issue(0, 1'b0, 4'd5, 8'h00);
        tick();
        chk("core_rd_gnt", 32'(gnt), 32'b001);
        chk("core_rd_addr", 32'(mem_addr), 5);
        req[0] = 1'b0;
        tick();
        chk("core_rd_rvalid", 32'(rvalid), 32'b001);
        chk("core_rd_rdata", 32'(rdata), 32'hA5);
        repeat (3) tick();

        reset_pulse();
        cont(3'b110, 1'b0, seq);
        chk("rr_sequence", 32'(seq), 32'({3'b100, 3'b010, 3'b100, 3'b010}));

        reset_pulse();
        cont(3'b111, 1'b1, seq);
        chk("starve_sequence", 32'(seq), 32'({3'b001, 3'b100, 3'b010, 3'b001}));

        issue(0, 1'b1, 4'd3, 8'h3C);
        issue(2, 1'b0, 4'd3, 8'h00);
        got = '0;
        n = 0;
        while (n < 50 && (req != 0 || got == 0)) begin
            tick();
            n++;
            for (int k = 0; k < 3; k++) if (gnt[k]) req[k] = 1'b0;
            if (rvalid[2]) got = rdata;
        end
        chk("raw_rdata", 32'(got), 32'h3C);
        repeat (3) tick();

        reset_pulse();
        issue(2, 1'b0, 4'd9, 8'h00);
        tick();
        chk("mid_rst_gnt", 32'(gnt), 32'b100);
        rst_n = 1'b0;
        req = '0;
        model_reset();
        tick();
        rst_n = 1'b1;
        chk("mid_rst_ptr", 32'(u_dut.ptr_q), 32'(REQ_RX));
        chk("mid_rst_cnts", 32'({u_dut.u_wait_rx.cnt_q, u_dut.u_wait_tx.cnt_q}), 0);
        repeat (5) tick();

        rand_run(3000);
        chk("read_queue_drained", 32'(rq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
